// File: rtl/axi_slave_mem_resp.sv
// rtl/axi_slave_mem_resp.sv - AXI4 single-burst slave responder backed by a word-addressed memory
// Serves one INCR read or write burst at a time; illegal or out-of-range beats answer SLVERR.
module axi_slave_mem_resp #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MEM_DEPTH);
  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e              state_q, state_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [7:0]          len_q, len_d;
  logic [ADDR_W-3:0]   start_q, start_d;
  logic                err_q, err_d;
  logic                legal_q, legal_d;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic [DATA_W-1:0]   mem_d [MEM_DEPTH];

  logic [ADDR_W-1:0]   idx_full;
  logic [IDX_W-1:0]    mem_idx;
  logic                in_range;
  logic                beat_ok;
  logic                last_beat;
  logic                unused_addr_bits;

  // Index is computed at full address width so a burst running past the top never wraps.
  assign idx_full  = ADDR_W'(start_q) + ADDR_W'(beat_cnt_q);
  assign mem_idx   = idx_full[IDX_W-1:0];
  assign in_range  = idx_full < DEPTH_L;
  assign beat_ok   = legal_q && in_range;
  assign last_beat = beat_cnt_q == len_q;
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    start_d    = start_q;
    err_d      = err_q;
    legal_d    = legal_q;
    mem_d      = mem_q;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          state_d    = RDATA;
          start_d    = araddr[ADDR_W-1:2];
          len_d      = arlen;
          beat_cnt_d = 8'd0;
          legal_d    = (arsize == SIZE_4B) && (arburst == BURST_INCR);
          err_d      = !legal_d;
        end else if (awvalid) begin
          state_d    = WDATA;
          start_d    = awaddr[ADDR_W-1:2];
          len_d      = awlen;
          beat_cnt_d = 8'd0;
          legal_d    = (awsize == SIZE_4B) && (awburst == BURST_INCR);
          err_d      = !legal_d;
        end
      end
      WDATA: begin
        if (wvalid) begin
          if (!in_range || (wlast != last_beat)) begin
            err_d = 1'b1;
          end
          if (beat_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb[b]) begin
                mem_d[mem_idx][b*8 +: 8] = wdata[b*8 +: 8];
              end
            end
          end
          beat_cnt_d = beat_cnt_q + 8'd1;
          // The burst length, not wlast, decides when the write ends.
          if (last_beat) begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (bready) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        if (rready) begin
          if (!beat_ok) begin
            err_d = 1'b1;
          end
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= 8'd0;
      len_q      <= 8'd0;
      start_q    <= '0;
      err_q      <= 1'b0;
      legal_q    <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      start_q    <= start_d;
      err_q      <= err_d;
      legal_q    <= legal_d;
      mem_q      <= mem_d;
    end
  end

  // Ready outputs are gated by reset so every output reads 0 while areset_n is low.
  assign arready = areset_n && (state_q == IDLE);
  assign awready = areset_n && (state_q == IDLE) && !arvalid;
  assign wready  = state_q == WDATA;
  assign bvalid  = state_q == WRESP;
  assign bresp   = ((state_q == WRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign rvalid  = state_q == RDATA;
  assign rdata   = ((state_q == RDATA) && beat_ok) ? mem_q[mem_idx] : '0;
  assign rresp   = ((state_q == RDATA) && !beat_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rlast   = (state_q == RDATA) && last_beat;

endmodule

// File: doc/axi_slave_mem_resp.md
Name: axi_slave_mem_resp

Overview:
AXI4 slave responder that is the memory-side counterpart to the team's AXI master model. It accepts one read or write burst at a time and services it from an internal word-addressed memory. It returns read data beats and write responses with full handshake compliance. It serves as the golden slave in the AXI environment and as a drop-in DUT endpoint for master-side benches.

Parameters:
ADDR_W, 32, address width of the AR/AW channels
DATA_W, 32, data width; fixed 4-byte beats, so wstrb is DATA_W/8 bits
MEM_DEPTH, 16, number of DATA_W words in internal memory (power of 2)

Ports:
aclk  in  1  clock; all logic on rising edge
areset_n  in  1  reset, asynchronous, active-low
awaddr  in  ADDR_W  write burst start byte address
awlen  in  8  write beats minus 1
awsize  in  3  beat size; only 3'b010 legal
awburst  in  2  burst type; only INCR (2'b01) legal
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read burst start byte address
arlen  in  8  read beats minus 1
arsize  in  3  beat size; only 3'b010 legal
arburst  in  2  burst type; only INCR legal
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_W  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- FSM states: IDLE, WDATA, WRESP, RDATA. Reset (async, areset_n=0) forces IDLE, clears memory to 0, beat counter to 0, error flag to 0, and all outputs to 0.
- Outputs decoded from state only:
  - arready = IDLE.
  - awready = IDLE && !arvalid. Reads win when arvalid and awvalid are both high in the same cycle; the write is held off until the next IDLE.
  - wready = WDATA.
  - bvalid = WRESP.
  - rvalid = RDATA.
- IDLE -> RDATA on arvalid&&arready. IDLE -> WDATA on awvalid&&awready. Both latch the start word index (addr[ADDR_W-1:2]) and len, and clear beat_cnt and err.
- Word index per beat = start index + beat_cnt. The beat is in range only if index < MEM_DEPTH. Indices do not wrap.
- Error flag is set if any of the following occurs:
  - size is not 3'b010;
  - burst is not INCR;
  - any beat is out of range;
  - wlast does not match (beat_cnt==len) on any accepted write beat.
  Once set, the error flag is sticky for the burst.
- WDATA: on wvalid&&wready, write each byte lane with wstrb set to mem[index] only if the beat is in range and size/burst are legal, then increment beat_cnt. Transition to WRESP on the beat where beat_cnt==len, regardless of wlast.
- WRESP: bresp = err ? 2'b10 (SLVERR) : 2'b00 (OKAY). Hold bvalid and bresp stable until bready. Return to IDLE on bvalid&&bready.
- RDATA:
  - rdata = mem[index] when in range and legal, else 0.
  - rresp = 2'b10 for an illegal/out-of-range beat, else 2'b00.
  - rlast = (beat_cnt==len).
  - rdata, rresp and rlast are stable while rvalid&&!rready.
  - On rvalid&&rready, increment beat_cnt. After the rlast beat, return to IDLE.
- Zero-cycle bubble: the first R beat or W acceptance occurs one cycle after the address handshake.
- Only one burst is outstanding; addresses are not accepted outside IDLE.
- A reset mid-burst aborts the burst immediately and leaves no partial response pending. Memory writes already committed are lost because memory clears on reset.
- awlen/arlen up to 255 are supported. beat_cnt is 8 bits and never wraps within a burst.

Test Plan:
- Write then read: AW addr 0x4, len 3, data 0xdeadbeef+0..3, wstrb 4'hF, wlast on beat 3 -> bresp 2'b00 one cycle after the last W. Then AR addr 0x4, len 3 -> rdata deadbeef, deadbef0, deadbef1, deadbef2, rresp 0, rlast on the 4th beat only.
- Backpressure: during the read, drop rready for 3 cycles mid-burst -> rvalid stays 1 and rdata/rlast stay stable. Hold bready low 5 cycles -> bvalid and bresp are held.
- Arbitration: arvalid and awvalid both high in IDLE -> arready=1, awready=0. The read completes first, then the write is accepted.
- Partial strobe: write 0xAABBCCDD at 0x0 with wstrb 4'b0101 over existing 0 -> readback 0x00BB00DD.
- Range error: AW addr 0x38 (index 14), len 3 -> beats 14 and 15 are written, beats 16 and 17 are dropped, bresp 2'b10. A read of the same burst -> rresp 0,0,2,2 and rdata 0 on the last two beats.
- Protocol error and reset: wlast asserted on beat 1 of a len-3 burst -> bresp 2'b10. Assert areset_n=0 mid-RDATA -> all outputs are 0 asynchronously, the FSM is in IDLE, and a subsequent read of the same address returns 0.
